// File: rtl/simple_ahb_bridge.sv
// Simple request/acknowledge bus to AHB-Lite master bridge, one SINGLE transfer per request.
// Optional stalled-transfer watchdog enabled by defining SIMPLE_AHB_TIMEOUT_EN.
module simple_ahb_bridge #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        req,
    output logic [31:0] rd,
    output logic        req_ack,
    output logic        err,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ERR,
        RESP
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;

`ifdef SIMPLE_AHB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stalled;
`else
    localparam int unusedTimeout = TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef SIMPLE_AHB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef SIMPLE_AHB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        size_d  = size_q;
        rd_d    = rd_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // An unsupported size is answered locally without touching the bus.
                    if (size == 2'd3) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ADDR;
                        addr_d  = addr;
                        wd_d    = wd;
                        we_d    = we;
                        size_d  = size;
                    end
                end
            end
            ADDR: begin
                if (hready) state_d = DATA;
            end
            DATA: begin
                if (hready) begin
                    state_d = RESP;
                    err_d   = hresp;
                    if (!hresp && !we_q) rd_d = hrdata;
                end else if (hresp) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (hready) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SIMPLE_AHB_TIMEOUT_EN
        // The counter only runs while a bus phase is stalled in the same state.
        cnt_d   = '0;
        stalled = (state_q == ADDR || state_q == DATA || state_q == ERR) && !hready;
        if (stalled && state_d == state_q) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = RESP;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    assign htrans  = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr   = addr_q;
    assign hwrite  = we_q;
    assign hsize   = {1'b0, size_q};
    assign hburst  = 3'b000;
    assign hwdata  = wd_q;
    assign rd      = rd_q;
    assign err     = err_q;
    assign req_ack = (state_q == RESP);

endmodule

// File: tb/tb_simple_ahb_bridge.sv
// Scoreboard bench for simple_ahb_bridge: directed requests, a scripted AHB slave and a
// monitor that checks address phases and acknowledges against queued expectations.
module tb_simple_ahb_bridge;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        we = 1'b0;
    logic [1:0]  size = '0;
    logic        req = 1'b0;
    logic [31:0] rd;
    logic        req_ack;
    logic        err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    simple_ahb_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .addr(addr), .wd(wd), .we(we), .size(size), .req(req),
        .rd(rd), .req_ack(req_ack), .err(err),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          ackCycle;
    } resp_t;

    typedef struct {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        int          cycle;
    } addr_t;

    resp_t respQ[$];
    addr_t addrQ[$];
    int compared = 0;
    int mismatched = 0;
    int ackCount = 0;
    int expAcks = 0;
    logic [31:0] rdModel = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scripted slave: mode 0 = OK after slvWaits, 1 = two-cycle error, 2 = single-cycle error.
    int          slvWaits = 0;
    int          slvMode = 0;
    logic        slvStuck = 1'b0;
    logic [31:0] slvData = '0;
    bit          dataPhase = 1'b0;
    int          k = 0;

    always @(negedge clk) begin
        hrdata = slvData;
        if (reset) begin
            dataPhase = 1'b0;
            hready = 1'b1;
            hresp = 1'b0;
        end else if (htrans == 2'b10) begin
            dataPhase = 1'b1;
            k = 0;
            hready = 1'b1;
            hresp = 1'b0;
        end else if (dataPhase) begin
            if (slvStuck) begin
                hready = 1'b0;
                hresp = 1'b0;
            end else begin
                case (slvMode)
                    0: begin hready = (k >= slvWaits); hresp = 1'b0; end
                    1: begin hready = (k >= 1); hresp = 1'b1; end
                    default: begin hready = 1'b1; hresp = 1'b1; end
                endcase
            end
            if (hready) dataPhase = 1'b0;
            k++;
        end else begin
            hready = 1'b1;
            hresp = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the bridge starts a transfer or acknowledges.
    resp_t       monResp;
    addr_t       monAddr;
    bit          pendW = 1'b0;
    logic [31:0] pendWdata = '0;
    int          lastNonseq = -10;

    always @(negedge clk) begin
        if (pendW) begin
            checkOutput("hwdata", hwdata, pendWdata);
            pendW = 1'b0;
        end
        if (req_ack === 1'b1) begin
            ackCount++;
            if (respQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ack: req_ack=1 at cycle %0d, required 0", cyc);
            end else begin
                monResp = respQ.pop_front();
                checkOutput("ack_cycle", cyc, monResp.ackCycle);
                checkOutput("rd", rd, monResp.rd);
                checkOutput("err", {31'b0, err}, {31'b0, monResp.err});
            end
        end
        if (htrans === 2'b10) begin
            if (addrQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_nonseq: htrans=10 at cycle %0d, required 00", cyc);
            end else begin
                monAddr = addrQ.pop_front();
                checkOutput("nonseq_cycle", cyc, monAddr.cycle);
                checkOutput("haddr", haddr, monAddr.haddr);
                checkOutput("hwrite", {31'b0, hwrite}, {31'b0, monAddr.hwrite});
                checkOutput("hsize", {29'b0, hsize}, {29'b0, monAddr.hsize});
                checkOutput("hburst", {29'b0, hburst}, 32'd0);
                checkOutput("nonseq_gap", {31'b0, cyc == lastNonseq + 1}, 32'd0);
                if (monAddr.hwrite) begin
                    pendW = 1'b1;
                    pendWdata = monAddr.hwdata;
                end
            end
            lastNonseq = cyc;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushAddr(input logic [31:0] a, input logic w, input logic [1:0] sz,
                            input logic [31:0] d, input int c);
        addr_t item;
        item.haddr = a; item.hwrite = w; item.hsize = {1'b0, sz}; item.hwdata = d; item.cycle = c;
        addrQ.push_back(item);
    endtask

    task automatic pushResp(input logic [31:0] r, input logic e, input int c);
        resp_t item;
        item.rd = r; item.err = e; item.ackCycle = c;
        respQ.push_back(item);
        expAcks++;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_htrans", {30'b0, htrans}, 32'd0);
        checkOutput("rst_haddr", haddr, 32'd0);
        checkOutput("rst_hwrite", {31'b0, hwrite}, 32'd0);
        checkOutput("rst_hsize", {29'b0, hsize}, 32'd0);
        checkOutput("rst_hwdata", hwdata, 32'd0);
        checkOutput("rst_rd", rd, 32'd0);
        checkOutput("rst_req_ack", {31'b0, req_ack}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdModel = '0;
    endtask

    // One request; the expected acknowledge cycle is counted from the cycle req is raised.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic wr,
                                 input logic [1:0] sz, input int mode, input int waits,
                                 input logic [31:0] data);
        int m;
        int ack;
        logic e;
        m = cyc;
        addr = a; wd = w; we = wr; size = sz; req = 1'b1;
        slvMode = mode; slvWaits = waits; slvData = data;
        if (sz == 2'd3) begin
            ack = m + 1;
            e = 1'b1;
        end else begin
            pushAddr(a, wr, sz, w, m + 1);
            if (mode == 0) begin
                ack = m + 3 + waits;
                e = 1'b0;
                if (!wr) rdModel = data;
            end else if (mode == 1) begin
                ack = m + 4;
                e = 1'b1;
            end else begin
                ack = m + 3;
                e = 1'b1;
            end
        end
        pushResp(rdModel, e, ack);
        waitCycles(1);
        req = 1'b0;
        addr = 32'hFFFF_FFFF; wd = 32'h0; we = ~wr; size = 2'd0;
        waitCycles(ack - cyc + 1);
    endtask

    initial begin
        int m;
        int acksBefore;
        resetDut();

        applyStimulus(32'h0000_0100, 32'h0, 1'b0, 2'd2, 0, 0, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_0003, 32'hA5, 1'b1, 2'd0, 0, 2, 32'h0BAD_F00D);
        applyStimulus(32'h0000_0202, 32'h0, 1'b0, 2'd1, 0, 1, 32'h1234_5678);
        applyStimulus(32'h0000_0300, 32'h0, 1'b0, 2'd2, 1, 0, 32'hBAD0_BAD0);
        applyStimulus(32'h0000_0304, 32'h5555_AAAA, 1'b1, 2'd2, 2, 0, 32'hCAFE_0000);
        applyStimulus(32'h0000_0308, 32'h0, 1'b0, 2'd3, 0, 0, 32'h9999_9999);
        applyStimulus(32'h0000_0400, 32'h0, 1'b0, 2'd2, 0, 0, 32'h0F0F_0000);

        // Back-to-back: req stays high across the first acknowledge.
        m = cyc;
        addr = 32'h500; wd = '0; we = 1'b0; size = 2'd2; req = 1'b1;
        slvMode = 0; slvWaits = 0; slvData = 32'h1111_2222;
        pushAddr(32'h500, 1'b0, 2'd2, 32'h0, m + 1);
        pushAddr(32'h504, 1'b0, 2'd2, 32'h0, m + 5);
        pushResp(32'h1111_2222, 1'b0, m + 3);
        pushResp(32'h3333_4444, 1'b0, m + 7);
        waitCycles(1);
        addr = 32'h504;
        waitCycles(2);
        slvData = 32'h3333_4444;
        waitCycles(2);
        req = 1'b0;
        rdModel = 32'h3333_4444;
        waitCycles(4);

        // Slave never becomes ready in the data phase.
        m = cyc;
        addr = 32'h600; wd = '0; we = 1'b0; size = 2'd2; req = 1'b1;
        slvMode = 0; slvWaits = 0; slvData = 32'h0000_7777; slvStuck = 1'b1;
        pushAddr(32'h600, 1'b0, 2'd2, 32'h0, m + 1);
`ifdef SIMPLE_AHB_TIMEOUT_EN
        pushResp(rdModel, 1'b1, m + 2 + TIMEOUT);
        waitCycles(1);
        req = 1'b0;
        waitCycles(TIMEOUT + 3);
        slvStuck = 1'b0;
        waitCycles(2);
`else
        waitCycles(1);
        req = 1'b0;
        acksBefore = ackCount;
        waitCycles(40);
        checkOutput("no_timeout_ack", ackCount, acksBefore);
        pushResp(32'h0000_7777, 1'b0, cyc + 1);
        rdModel = 32'h0000_7777;
        slvStuck = 1'b0;
        waitCycles(4);
`endif

        // Reset while the data phase is stalled: no acknowledge may follow.
        m = cyc;
        addr = 32'h700; wd = 32'h0; we = 1'b0; size = 2'd2; req = 1'b1;
        slvMode = 0; slvWaits = 5; slvData = 32'h4444_4444;
        pushAddr(32'h700, 1'b0, 2'd2, 32'h0, m + 1);
        waitCycles(1);
        req = 1'b0;
        waitCycles(1);
        resetDut();
        waitCycles(8);

        applyStimulus(32'h0000_0800, 32'h0, 1'b0, 2'd2, 0, 0, 32'h8765_4321);
        waitCycles(5);

        checkOutput("ack_total", ackCount, expAcks);
        checkOutput("resp_queue_left", respQ.size(), 32'd0);
        checkOutput("addr_queue_left", addrQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
